// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m
// Two-master, one-slave Wishbone-classic arbiter. Registered round-robin
// arbitration in which each grant carries exactly one transfer, and a
// per-grant wait counter that aborts hung transfers with an error pulse to
// the owning master. The slave side is a purely combinational mux of the
// owner's request lines. The owner is held in registered state, so an
// asynchronous reset drops the bus in the same cycle that reset asserts.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,

  // Master 0 (core side)
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  // Master 1 (core side)
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  // Shared slave (controller side)
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,

  // Status
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  // The state encoding matches grant_o, so grant_o is the state register.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT0 = 2'b01;
  localparam logic [1:0] ST_GRANT1 = 2'b10;

  // The counter only has to reach TIMEOUT_CYCLES. It keeps at least one bit
  // so that the disabled configuration (0) still elaborates.
  localparam int              CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  // last_grant encoding: 0 = master 0 served last, 1 = master 1 served last.
  logic [1:0]       state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic             timeout_q,    timeout_d;

  logic m0_req;
  logic m1_req;
  logic granted;
  logic owner_cyc;
  logic owner_id;
  logic end_ack;
  logic end_abort;
  logic end_timeout;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;

  // Classify how the current grant ends. The ack outranks both abort and
  // timeout; an abort outranks a timeout because the master has already
  // left the bus and does not need an error.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so a path that
    // skips an assignment cannot leave a latch holding the old value.
    granted     = 1'b0;
    owner_cyc   = 1'b0;
    owner_id    = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        granted   = 1'b1;
        owner_cyc = m0_cyc_i;
        owner_id  = 1'b0;
      end
      ST_GRANT1: begin
        granted   = 1'b1;
        owner_cyc = m1_cyc_i;
        owner_id  = 1'b1;
      end
      default: ;
    endcase
    end_ack     = granted & s_ack_i;
    end_abort   = granted & ~s_ack_i & ~owner_cyc;
    end_timeout = TIMEOUT_EN & granted & ~s_ack_i & owner_cyc &
                  (wait_cnt_q == CNT_LIMIT);
  end

  // Next-state logic: round-robin arbitration, grant termination and the
  // saturating wait counter.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q | end_timeout;

    case (state_q)
      ST_IDLE: begin
        // Clearing here means every entry into a grant starts from zero.
        wait_cnt_d = '0;
        if (m0_req && m1_req) begin
          state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_req) begin
          state_d = ST_GRANT0;
        end else if (m1_req) begin
          state_d = ST_GRANT1;
        end
      end

      ST_GRANT0, ST_GRANT1: begin
        if (end_ack || end_abort || end_timeout) begin
          state_d      = ST_IDLE;
          last_grant_d = owner_id;
        end else if (wait_cnt_q != CNT_SAT) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset leaves last_grant pointing at master 1, so
  // master 0 wins the first contention.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of the statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Slave-side mux: mirror the owner's request lines, and drive all zeros
  // when the bus is idle.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    case (state_q)
      ST_GRANT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
      end
      ST_GRANT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
      end
      default: ;
    endcase
  end

  // Master-side returns. Read data is broadcast to both masters, and only
  // the owner's ack or err qualifies it.
  always_comb begin
    m0_ack_o = (state_q == ST_GRANT0) & s_ack_i;
    m1_ack_o = (state_q == ST_GRANT1) & s_ack_i;
    m0_err_o = (state_q == ST_GRANT0) & end_timeout;
    m1_err_o = (state_q == ST_GRANT1) & end_timeout;
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign grant_o   = state_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed testbench for wb_arbiter_2m (TIMEOUT_CYCLES = 4). The expected
// acknowledgements and grant sequences are queued when the stimulus is
// driven. They are popped and compared when the DUT responds.
module tb_wb_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m0_ack, m0_err;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          s_ack;
  logic [1:0]    grant;
  logic          timeout;

  // When auto_ack is set, the slave model is a zero-wait slave.
  logic auto_ack;
  logic ack_drv;
  assign s_ack = auto_ack ? (s_cyc & s_stb) : ack_drv;

  typedef struct {
    int unsigned m;
    logic [31:0] data;
  } exp_t;

  exp_t       sb_ack[$];
  logic [1:0] sb_grant[$];

  int n_checks = 0;
  int n_err    = 0;

  wb_arbiter_2m #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_addr_i(m0_addr),
    .m0_data_i(m0_wdata),
    .m0_data_o(m0_rdata),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_addr_i(m1_addr),
    .m1_data_i(m1_wdata),
    .m1_data_o(m1_rdata),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_addr_o (s_addr),
    .s_data_o (s_wdata),
    .s_data_i (s_rdata),
    .s_ack_i  (s_ack),
    .grant_o  (grant),
    .timeout_o(timeout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] data);
    m0_cyc = req; m0_stb = req; m0_we = we; m0_addr = addr; m0_wdata = data;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] data);
    m1_cyc = req; m1_stb = req; m1_we = we; m1_addr = addr; m1_wdata = data;
  endtask

  // Pop the oldest expected acknowledgement and compare it with the ack
  // lines and the returned data that are visible now.
  task automatic expect_ack(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb_ack.size() > 0), 64'd1);
    if (sb_ack.size() > 0) begin
      e = sb_ack.pop_front();
      check({tag, "_ack_m0"}, 64'(m0_ack), 64'(e.m == 0));
      check({tag, "_ack_m1"}, 64'(m1_ack), 64'(e.m == 1));
      check({tag, "_data"}, (e.m == 0) ? 64'(m0_rdata) : 64'(m1_rdata), 64'(e.data));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    auto_ack = 1'b0;
    ack_drv  = 1'b0;
    s_rdata  = 32'h5A5A_0001;
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);

    // ---------------- Reset values ----------------
    #3;
    check("rst_grant",   64'(grant), 64'd0);
    check("rst_s_cyc",   64'(s_cyc), 64'd0);
    check("rst_s_bus",   64'({s_stb, s_we, s_addr, s_wdata}), 64'd0);
    check("rst_acks",    64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_m0_data", 64'(m0_rdata), 64'h5A5A_0001);
    check("rst_m1_data", 64'(m1_rdata), 64'h5A5A_0001);
    step();
    rst_n = 1'b1;
    step();

    // ---------------- m0 read at 0x100, slave acks two cycles after the grant ----------------
    set_m0(1'b1, 1'b0, 32'h100, '0);
    #1;
    check("t1_cyc_before_edge", 64'(s_cyc), 64'd0);
    step();
    check("t1_grant", 64'(grant), 64'b01);
    check("t1_s_cyc", 64'(s_cyc), 64'd1);
    check("t1_s_addr", 64'(s_addr), 64'h100);
    check("t1_s_we", 64'(s_we), 64'd0);
    sb_ack.push_back('{0, 32'hCAFE_F00D});
    step();
    check("t1_no_early_ack", 64'(m0_ack), 64'd0);
    step();
    ack_drv = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    #1;
    expect_ack("t1");
    step();
    set_m0(1'b0, 1'b0, '0, '0);
    ack_drv = 1'b0;
    #1;
    check("t1_grant_idle", 64'(grant), 64'b00);
    check("t1_s_cyc_idle", 64'(s_cyc), 64'd0);

    // ---------------- m1 write 0x1234 to 0x20 ----------------
    set_m1(1'b1, 1'b1, 32'h20, 32'h1234);
    step();
    check("t3_grant", 64'(grant), 64'b10);
    check("t3_s_we", 64'(s_we), 64'd1);
    check("t3_s_addr", 64'(s_addr), 64'h20);
    check("t3_s_data", 64'(s_wdata), 64'h1234);
    check("t3_m0_ack_quiet", 64'(m0_ack), 64'd0);
    sb_ack.push_back('{1, 32'hDEAD_BEEF});
    step();
    check("t3_m0_ack_quiet2", 64'(m0_ack), 64'd0);
    ack_drv = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    #1;
    expect_ack("t3");
    step();
    set_m1(1'b0, 1'b0, '0, '0);
    ack_drv = 1'b0;
    #1;
    check("t3_grant_idle", 64'(grant), 64'b00);

    // ---------------- Round-robin with both masters requesting, zero-wait slave ----------------
    auto_ack = 1'b1;
    s_rdata  = 32'h0BAD_F00D;
    sb_grant.push_back(2'b01);
    sb_grant.push_back(2'b00);
    sb_grant.push_back(2'b10);
    sb_grant.push_back(2'b00);
    sb_grant.push_back(2'b01);
    sb_grant.push_back(2'b00);
    set_m0(1'b1, 1'b0, 32'h40, '0);
    set_m1(1'b1, 1'b0, 32'h80, '0);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] g;
      step();
      g = sb_grant.pop_front();
      check($sformatf("rr_grant_%0d", i), 64'(grant), 64'(g));
      check($sformatf("rr_ack0_%0d", i), 64'(m0_ack), 64'(g[0]));
      check($sformatf("rr_ack1_%0d", i), 64'(m1_ack), 64'(g[1]));
    end
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);
    auto_ack = 1'b0;
    step();
    check("rr_idle", 64'(grant), 64'b00);

    // ---------------- Ack in the exact timeout cycle: ack only, no err ----------------
    set_m0(1'b1, 1'b0, 32'h200, '0);
    step();
    check("ta_grant", 64'(grant), 64'b01);
    for (int i = 2; i <= 4; i++) begin
      step();
      check($sformatf("ta_no_err_c%0d", i), 64'(m0_err), 64'd0);
    end
    step();
    sb_ack.push_back('{0, 32'h1111_2222});
    ack_drv = 1'b1;
    s_rdata = 32'h1111_2222;
    #1;
    expect_ack("ta");
    check("ta_no_err_c5", 64'(m0_err), 64'd0);
    step();
    set_m0(1'b0, 1'b0, '0, '0);
    ack_drv = 1'b0;
    #1;
    check("ta_timeout_clear", 64'(timeout), 64'd0);
    check("ta_grant_idle", 64'(grant), 64'b00);

    // ---------------- Timeout on m0 while m1 is pending ----------------
    set_m0(1'b1, 1'b0, 32'h300, '0);
    step();
    check("to_grant0", 64'(grant), 64'b01);
    set_m1(1'b1, 1'b0, 32'h380, '0);
    for (int i = 2; i <= 4; i++) begin
      step();
      check($sformatf("to_no_err_c%0d", i), 64'(m0_err), 64'd0);
      check($sformatf("to_grant_c%0d", i), 64'(grant), 64'b01);
    end
    step();
    check("to_err_c5", 64'(m0_err), 64'd1);
    check("to_m1_err_quiet", 64'(m1_err), 64'd0);
    check("to_no_ack", 64'(m0_ack), 64'd0);
    check("to_flag_not_yet", 64'(timeout), 64'd0);
    step();
    set_m0(1'b0, 1'b0, '0, '0);
    #1;
    check("to_err_one_cycle", 64'(m0_err), 64'd0);
    check("to_flag_set", 64'(timeout), 64'd1);
    check("to_bus_idle", 64'(s_cyc), 64'd0);
    check("to_grant_idle", 64'(grant), 64'b00);
    step();
    check("to_grant1_next", 64'(grant), 64'b10);
    check("to_s_addr_m1", 64'(s_addr), 64'h380);
    sb_ack.push_back('{1, 32'h3333_4444});
    ack_drv = 1'b1;
    s_rdata = 32'h3333_4444;
    #1;
    expect_ack("to_m1");
    step();
    set_m1(1'b0, 1'b0, '0, '0);
    ack_drv = 1'b0;
    #1;
    check("to_flag_sticky", 64'(timeout), 64'd1);

    // ---------------- m0 drops cyc mid-grant ----------------
    set_m0(1'b1, 1'b0, 32'h400, '0);
    step();
    check("ab_grant", 64'(grant), 64'b01);
    check("ab_s_cyc", 64'(s_cyc), 64'd1);
    step();
    set_m0(1'b0, 1'b0, 32'h400, '0);
    #1;
    check("ab_s_cyc_mirror", 64'(s_cyc), 64'd0);
    check("ab_no_ack", 64'(m0_ack), 64'd0);
    step();
    check("ab_grant_idle", 64'(grant), 64'b00);
    check("ab_no_ack_err", 64'({m0_ack, m0_err}), 64'd0);
    // An abort counts as m0 being served, so m1 wins the next contention.
    set_m0(1'b1, 1'b0, 32'h410, '0);
    set_m1(1'b1, 1'b0, 32'h480, '0);
    step();
    check("ab_rr_grant1", 64'(grant), 64'b10);
    sb_ack.push_back('{1, 32'h5555_6666});
    ack_drv = 1'b1;
    s_rdata = 32'h5555_6666;
    #1;
    expect_ack("ab_m1");
    step();
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);
    ack_drv = 1'b0;
    #1;
    check("ab_end_idle", 64'(grant), 64'b00);

    // ---------------- Reset asserted mid-transfer ----------------
    set_m1(1'b1, 1'b0, 32'h500, '0);
    step();
    check("rm_grant", 64'(grant), 64'b10);
    check("rm_s_cyc", 64'(s_cyc), 64'd1);
    #2;
    rst_n   = 1'b0;
    ack_drv = 1'b1;
    #1;
    check("rm_s_cyc_drop", 64'(s_cyc), 64'd0);
    check("rm_grant_drop", 64'(grant), 64'b00);
    check("rm_no_ack", 64'(m1_ack), 64'd0);
    check("rm_timeout_cleared", 64'(timeout), 64'd0);
    step();
    rst_n   = 1'b1;
    ack_drv = 1'b0;
    set_m1(1'b0, 1'b0, '0, '0);
    step();
    check("rm_idle_after", 64'(grant), 64'b00);
    // After reset, master 0 wins the first contention again.
    set_m0(1'b1, 1'b0, 32'h600, '0);
    set_m1(1'b1, 1'b0, 32'h680, '0);
    step();
    check("rm_first_m0", 64'(grant), 64'b01);
    sb_ack.push_back('{0, 32'h7777_8888});
    ack_drv = 1'b1;
    s_rdata = 32'h7777_8888;
    #1;
    expect_ack("rm_m0");
    step();
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);
    ack_drv = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
